// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - glyph codes, segment bit positions and glyph ROM shared by display logic
package seg_pkg;

    typedef logic [3:0] glyph_code_t;

    // Glyph codes with a letter meaning, shared with the signal-select logic
    localparam glyph_code_t G_O     = 4'h0;
    localparam glyph_code_t G_R     = 4'h4;
    localparam glyph_code_t G_H     = 4'h6;
    localparam glyph_code_t G_L     = 4'h7;
    localparam glyph_code_t G_A     = 4'hA;
    localparam glyph_code_t G_BLANK = 4'hD;
    localparam glyph_code_t G_E     = 4'hE;
    localparam glyph_code_t G_F     = 4'hF;

    // Bit positions of each segment on the seg_out buses
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Glyph ROM: code -> segments a..g in [7:1], dp position always cleared
    function automatic logic [7:0] decode(input glyph_code_t code);
        logic [7:0] segs;
        case (code)
            G_O:     segs = 8'hFC;
            4'h1:    segs = 8'h60;
            4'h2:    segs = 8'hDA;
            4'h3:    segs = 8'hF2;
            G_R:     segs = 8'h0A;
            4'h5:    segs = 8'hB6;
            G_H:     segs = 8'h6E;
            G_L:     segs = 8'h1C;
            4'h8:    segs = 8'hFE;
            4'h9:    segs = 8'hF6;
            G_A:     segs = 8'hEE;
            4'hB:    segs = 8'h3E;
            4'hC:    segs = 8'h9C;
            G_BLANK: segs = 8'h00;
            G_E:     segs = 8'h9E;
            G_F:     segs = 8'h8E;
            default: segs = 8'h00;
        endcase
        return segs;
    endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// rtl/seg_tick_gen.sv - free-running divider producing a one-cycle tick every DIV cycles
module seg_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt_q;
    logic [CW-1:0] div_cnt_d;

    // Count 0..DIV-1 and wrap
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_cnt_q == LAST) begin
            div_cnt_d = '0;
        end
    end

    // Divider register, restarts from zero on reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign tick_o = (div_cnt_q == LAST);

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - frame-latched 8-digit two-bank multiplexed seven-segment driver
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] digits,
    input  logic [7:0]  dp,
    input  logic [7:0]  blink_mask,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out0,
    output logic [7:0]  seg_out1
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int FW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic          tick;

    logic [2:0]    idx_q;
    logic [FW-1:0] frame_cnt_q;
    logic          blink_on_q;
    logic [31:0]   snap_digits_q;
    logic [7:0]    snap_dp_q;
    logic [7:0]    snap_mask_q;
    logic [7:0]    seg_en_q;
    logic [7:0]    seg_out0_q;
    logic [7:0]    seg_out1_q;

    logic [31:0]   src_digits;
    logic [7:0]    src_dp;
    logic [7:0]    src_mask;
    glyph_code_t   code;
    logic [7:0]    glyph_d;
    logic [7:0]    seg_en_d;
    logic [7:0]    seg_out0_d;
    logic [7:0]    seg_out1_d;

    seg_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk_i  (clk),
        .rst_i  (rst),
        .tick_o (tick)
    );

    // Digit 0 is drawn on the same edge that latches the frame, so it reads the live inputs
    always_comb begin
        src_digits = snap_digits_q;
        src_dp     = snap_dp_q;
        src_mask   = snap_mask_q;
        if (idx_q == 3'd0) begin
            src_digits = digits;
            src_dp     = dp;
            src_mask   = blink_mask;
        end
    end

    // Decode the selected digit, insert its decimal point and apply blink blanking
    always_comb begin
        code             = src_digits[{idx_q, 2'b00} +: 4];
        glyph_d          = decode(code);
        glyph_d[SEG_DP]  = src_dp[idx_q];
        if (!blink_on_q && src_mask[idx_q]) begin
            glyph_d = 8'h00;
        end
    end

    // Route the glyph to the bank that owns the current digit
    always_comb begin
        seg_en_d   = 8'h01 << idx_q;
        seg_out0_d = 8'h00;
        seg_out1_d = 8'h00;
        if (idx_q[2]) begin
            seg_out0_d = glyph_d;
        end else begin
            seg_out1_d = glyph_d;
        end
    end

    // Scan position, frame snapshot, blink phase and registered pin outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q         <= 3'd0;
            frame_cnt_q   <= '0;
            blink_on_q    <= 1'b1;
            snap_digits_q <= 32'hDDDD_DDDD;
            snap_dp_q     <= 8'h00;
            snap_mask_q   <= 8'h00;
            seg_en_q      <= 8'h00;
            seg_out0_q    <= 8'h00;
            seg_out1_q    <= 8'h00;
        end else if (tick) begin
            idx_q      <= idx_q + 3'd1;
            seg_en_q   <= seg_en_d;
            seg_out0_q <= seg_out0_d;
            seg_out1_q <= seg_out1_d;
            if (idx_q == 3'd0) begin
                snap_digits_q <= digits;
                snap_dp_q     <= dp;
                snap_mask_q   <= blink_mask;
            end
            if (idx_q == 3'd7) begin
                if (frame_cnt_q == FRAME_LAST) begin
                    frame_cnt_q <= '0;
                    blink_on_q  <= ~blink_on_q;
                end else begin
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                end
            end
        end
    end

    assign seg_en   = seg_en_q;
    assign seg_out0 = seg_out0_q;
    assign seg_out1 = seg_out1_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - scoreboard bench for seg_scan_driver against a tick-count reference model
module tb_seg_scan_driver;

    localparam int DIV = 4;
    localparam int BF  = 2;

    localparam logic [7:0] GLYPH_TAB [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h0A, 8'hB6, 8'h6E, 8'h1C,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h00, 8'h9E, 8'h8E
    };

    typedef struct {
        int         cyc;
        logic [7:0] en;
        logic [7:0] o0;
        logic [7:0] o1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] digits = 32'h0;
    logic [7:0]  dp = 8'h0;
    logic [7:0]  blink_mask = 8'h0;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out0;
    logic [7:0]  seg_out1;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];

    // reference model state: edges since reset release and the frame's latched inputs
    int          m_cyc = 0;
    logic [31:0] m_digits;
    logic [7:0]  m_dp;
    logic [7:0]  m_mask;

    seg_scan_driver #(
        .CLK_HZ       (4000),
        .SCAN_HZ      (1000),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp         (dp),
        .blink_mask (blink_mask),
        .seg_en     (seg_en),
        .seg_out0   (seg_out0),
        .seg_out1   (seg_out1)
    );

    always #5 clk = ~clk;

    // Expected display for the k-th digit slot since reset
    task automatic push_expected(input int k, input int cyc);
        exp_t       e;
        int         idx;
        int         frame;
        bit         lit;
        logic [7:0] g;
        logic [3:0] code;
        idx   = k % 8;
        frame = k / 8;
        if (idx == 0) begin
            m_digits = digits;
            m_dp     = dp;
            m_mask   = blink_mask;
        end
        lit  = ((frame / BF) % 2) == 0;
        code = m_digits[idx*4 +: 4];
        g    = GLYPH_TAB[code] | {7'b0, m_dp[idx]};
        if (!lit && m_mask[idx]) g = 8'h00;
        e.cyc = cyc;
        e.en  = 8'(1 << idx);
        e.o0  = (idx >= 4) ? g : 8'h00;
        e.o1  = (idx < 4) ? g : 8'h00;
        exp_q.push_back(e);
    endtask

    // Advance one clock with the currently driven inputs
    task automatic step();
        if (rst) begin
            m_cyc = 0;
        end else begin
            m_cyc++;
            if (m_cyc % DIV == 0) push_expected(m_cyc / DIV - 1, m_cyc);
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        run(n);
        rst = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation every time the pins change
    initial begin : monitor
        int         mon_cyc;
        logic [23:0] prev;
        exp_t       e;
        mon_cyc = 0;
        prev    = 24'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mon_cyc = 0;
                check("reset_outputs", {8'h0, seg_en, seg_out0, seg_out1}, 32'h0);
                check("pending_at_reset", exp_q.size(), 0);
                exp_q.delete();
                prev = 24'h0;
            end else begin
                mon_cyc++;
                if ({seg_en, seg_out0, seg_out1} !== prev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_change", {8'h0, seg_en, seg_out0, seg_out1}, {8'h0, prev});
                    end else begin
                        e = exp_q.pop_front();
                        check("tick_cycle", mon_cyc, e.cyc);
                        check("seg_en", seg_en, e.en);
                        check("seg_out0", seg_out0, e.o0);
                        check("seg_out1", seg_out1, e.o1);
                    end
                    prev = {seg_en, seg_out0, seg_out1};
                end
            end
        end
    end

    initial begin : stimulus
        int guard;
        @(negedge clk);
        // power-up reset, then reset mid-scan
        do_reset(2);
        digits = 32'h1234_5678;
        run(10);
        do_reset(3);

        // scan order
        digits = 32'h6E77_0DDD;
        dp = 8'h00;
        blink_mask = 8'h00;
        run(64);

        // glyph ROM through digit 0, one frame per code
        for (int c = 0; c < 16; c++) begin
            digits = {28'hDDD_DDDD, 4'(c)};
            run(32);
        end

        // snapshot: change inputs partway through a frame
        digits = 32'hA2DD_DDDD;
        guard = 0;
        while ((m_cyc / DIV) % 8 != 5 && guard < 100) begin
            step();
            guard++;
        end
        check("align_idx5", guard < 100, 1);
        run(2);
        digits = 32'hF4EE_DDDD;
        run(64);

        // decimal point and blink
        digits = 32'h1DDD_DDD3;
        dp = 8'h80;
        blink_mask = 8'h01;
        run(32 * 6);

        // reset while the blinking digit is dark
        guard = 0;
        while (!((((m_cyc / DIV) / 8 / BF) % 2 == 1) && ((m_cyc / DIV) % 8 == 3)) && guard < 1000) begin
            step();
            guard++;
        end
        check("align_blink_off", guard < 1000, 1);
        do_reset(2);
        run(64);

        // randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(39) == 0) digits = $urandom;
            if ($urandom_range(39) == 0) dp = 8'($urandom);
            if ($urandom_range(39) == 0) blink_mask = 8'($urandom);
            if ($urandom_range(299) == 0) do_reset($urandom_range(3, 1));
            step();
        end

        run(3);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
